// File: rtl/i2s_pkg.sv
// i2s_pkg
// Shared definitions for the I2S / DSP-mode (PCM Format A) clock master:
//   - i2sState_t : sequencer state (IDLE, RUN, STOP)
//   - cntWidth() : bit width needed for a counter that takes values 0..count-1
// No ports; imported by i2s_sclk_gen and i2s_dsp_master.

package i2s_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } i2sState_t;

   // A counter running 0..count-1 needs ceil(log2(count)) bits, but never
   // less than one bit so that degenerate ranges still give a legal vector.
   function automatic int cntWidth(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// i2s_sclk_gen
// Divides clk down to the serial bit clock. Each SCLK period starts with
// sclk low for SCLK_DIV clk cycles, followed by sclk high for SCLK_DIV cycles.
// The rise/fall strobes are high during the clk cycle whose closing edge
// produces the corresponding sclk transition, so the parent can update its
// own registers on exactly the same edge that sclk toggles.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   run      in   divider enable; while low, sclk is held 0 and the phase
//                 counter is parked at 0
//   sclk     out  serial bit clock (registered)
//   riseStb  out  high in the cycle before sclk goes 0->1
//   fallStb  out  high in the cycle before sclk goes 1->0

module i2s_sclk_gen
   import i2s_pkg::*;
#(
   parameter int SCLK_DIV = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic sclk,
   output logic riseStb,
   output logic fallStb
);

   localparam int DW = cntWidth(2 * SCLK_DIV);
   localparam logic [DW-1:0] RISE_AT = DW'(SCLK_DIV - 1);
   localparam logic [DW-1:0] FALL_AT = DW'(2 * SCLK_DIV - 1);

   logic [DW-1:0] divCnt;

   // The strobes are decoded straight from the phase counter so they line up
   // with the edge that changes sclk, not one cycle after it.
   assign riseStb = run && (divCnt == RISE_AT);
   assign fallStb = run && (divCnt == FALL_AT);

   // Phase counter walks 0..2*SCLK_DIV-1 once per SCLK period. Phase 0 is the
   // first low cycle, so starting the counter from 0 when run rises gives a
   // full-length low half before the first rising edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divCnt <= '0;
         sclk   <= 1'b0;
      end else if (!run) begin
         divCnt <= '0;
         sclk   <= 1'b0;
      end else if (fallStb) begin
         divCnt <= '0;
         sclk   <= 1'b0;
      end else begin
         divCnt <= divCnt + DW'(1);
         if (riseStb) begin
            sclk <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2s_dsp_master.sv
// i2s_dsp_master
// Clock/frame master for I2S PCM Format A (DSP mode). Generates SCLK and a
// one-SCLK-wide LRCLK pulse at the start of every frame, shifts audio_o out
// MSB-first starting in the period after the pulse, and shifts the codec's
// word in on SCLK rising edges.
//
// Parameters:
//   BITS         data bits per frame (>= 2)
//   FRAME_SCLKS  SCLK periods per frame (>= BITS)
//   SCLK_DIV     clk cycles per SCLK half-period (>= 1)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   en         in   run request, looked at in IDLE and at frame boundaries
//   sclk       out  serial bit clock
//   lrclk      out  frame sync pulse (high for period 0 only)
//   sdout      out  serial data to codec DIN
//   sdin       in   serial data from codec DOUT (already registered)
//   audio_o    in   word to transmit, captured at the start of period 1
//   audio_i    out  last complete received word
//   frame_stb  out  one-cycle pulse when audio_i updates
//   busy       out  high while in RUN or STOP
//
// Build option:
//   I2S_MASTER_LOOPBACK_EN  when defined, the receive path samples the
//                           internal sdout instead of sdin (sdin ignored).

module i2s_dsp_master
   import i2s_pkg::*;
#(
   parameter int BITS        = 64,
   parameter int FRAME_SCLKS = 64,
   parameter int SCLK_DIV    = 2
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   output logic            sclk,
   output logic            lrclk,
   output logic            sdout,
   input  logic            sdin,
   input  logic [BITS-1:0] audio_o,
   output logic [BITS-1:0] audio_i,
   output logic            frame_stb,
   output logic            busy
);

   localparam int PW = cntWidth(FRAME_SCLKS);
   localparam logic [PW-1:0] LAST_P = PW'(FRAME_SCLKS - 1);
   localparam logic [PW-1:0] LSB_P  = PW'(BITS % FRAME_SCLKS);
   localparam bit NO_PAD = (BITS == FRAME_SCLKS);

   i2sState_t       state;
   logic [PW-1:0]   period;
   logic [BITS-1:0] txShift;
   logic [BITS-2:0] rxShift;
   logic [BITS-1:0] rxNext;
   logic            haveFrame;
   logic            rxBit;
   logic            sclkRise;
   logic            sclkFall;

   i2s_sclk_gen #(
      .SCLK_DIV (SCLK_DIV)
   ) sclkGen (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (busy),
      .sclk    (sclk),
      .riseStb (sclkRise),
      .fallStb (sclkFall)
   );

   // The transmit register shifts in zeros, so once the word has gone out its
   // MSB is 0 for the padding periods and for the first period after entry.
   // Driving sdout straight from that flop keeps it changing only on falls.
   assign sdout = txShift[BITS-1];

`ifdef I2S_MASTER_LOOPBACK_EN
   assign rxBit = txShift[BITS-1];
`else
   assign rxBit = sdin;
`endif

   // Only BITS-1 bits of history are kept; the LSB is appended on the fly
   // when the finished word is copied out.
   assign rxNext = {rxShift, rxBit};

   // Frame sequencer. Everything advances on the clk edge where sclk falls,
   // which is also where a new SCLK period begins. Leaving the last period of
   // a frame is the frame boundary where en is consulted. Without padding the
   // LSB of the frame still has to be sent in the following period 0, which
   // is what STOP is for; with padding the LSB is already done at the
   // boundary, so the sequencer drops straight back to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         period    <= '0;
         lrclk     <= 1'b0;
         txShift   <= '0;
         haveFrame <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  period <= '0;
                  lrclk  <= 1'b1;
               end
            end

            RUN: begin
               if (sclkFall) begin
                  if (period == LAST_P) begin
                     if (en) begin
                        period  <= '0;
                        lrclk   <= 1'b1;
                        txShift <= txShift << 1;
                     end else if (NO_PAD) begin
                        state   <= STOP;
                        period  <= '0;
                        lrclk   <= 1'b0;
                        txShift <= txShift << 1;
                     end else begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        period    <= '0;
                        lrclk     <= 1'b0;
                        txShift   <= '0;
                        haveFrame <= 1'b0;
                     end
                  end else if (period == '0) begin
                     period    <= PW'(1);
                     lrclk     <= 1'b0;
                     txShift   <= audio_o;
                     haveFrame <= 1'b1;
                  end else begin
                     period  <= period + PW'(1);
                     txShift <= txShift << 1;
                  end
               end
            end

            STOP: begin
               if (sclkFall) begin
                  state     <= IDLE;
                  busy      <= 1'b0;
                  period    <= '0;
                  lrclk     <= 1'b0;
                  txShift   <= '0;
                  haveFrame <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               period    <= '0;
               lrclk     <= 1'b0;
               txShift   <= '0;
               haveFrame <= 1'b0;
            end
         endcase
      end
   end

   // Receive path. A bit is taken on every SCLK rise while active. The word
   // is published on the rise of the LSB period, but only if its MSB was
   // captured in this run; this stops the period 0 that follows RUN entry
   // from being taken as the tail of a frame that never happened. The partial
   // word is dropped whenever the master is idle or reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxShift   <= '0;
         audio_i   <= '0;
         frame_stb <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         if (!busy) begin
            rxShift <= '0;
         end else if (sclkRise) begin
            rxShift <= rxNext[BITS-2:0];
            if ((period == LSB_P) && haveFrame) begin
               audio_i   <= rxNext;
               frame_stb <= 1'b1;
            end
         end
      end
   end

endmodule
